// File: rtl/mult_seq_ctrl_if.sv
// EX-stage handshake between the pipeline (master) and the iterative
// multiply sequencer (slave).
interface mult_seq_ctrl_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic [3:0]      alu_ctrl_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            result_valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, alu_ctrl_i, op_a_i, op_b_i, flush_i,
    input  stall_o, busy_o, result_valid_o, result_o
  );

  modport slave (
    input  valid_i, alu_ctrl_i, op_a_i, op_b_i, flush_i,
    output stall_o, busy_o, result_valid_o, result_o
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Shift-add multiply sequencer: one multiplier bit per cycle, stalls EX until done.
// Define MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module mult_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_seq_ctrl_if.slave   bus
);

  localparam logic [3:0]       ALU_MULT = 4'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              start;
  logic              last_iter;
  logic              stall;
  logic              result_valid;

  assign start = bus.valid_i & (bus.alu_ctrl_i == ALU_MULT) & ~bus.flush_i;

`ifdef MULT_EARLY_EXIT_EN
  assign last_iter = (cnt_q == CNT_LAST) || ((mplier_q >> 1) == '0);
`else
  assign last_iter = (cnt_q == CNT_LAST);
`endif

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    cnt_d        = cnt_q;
    stall        = 1'b0;
    result_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall = start;
        if (start) begin
          acc_d    = '0;
          mcand_d  = bus.op_a_i;
          mplier_d = bus.op_b_i;
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          state_d = ST_DONE;
        end
      end
      // The finished mult is still on the inputs here, so start is not looked at.
      ST_DONE: begin
        result_valid = 1'b1;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flush kills the EX instruction outright: freeze datapath, mask outputs.
    if (bus.flush_i) begin
      state_d      = ST_IDLE;
      acc_d        = acc_q;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      cnt_d        = cnt_q;
      stall        = 1'b0;
      result_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.stall_o        = stall;
  assign bus.busy_o         = (state_q == ST_BUSY);
  assign bus.result_valid_o = result_valid;
  assign bus.result_o       = acc_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: vector table of back-to-back mults plus
// hand-written flush, reset and non-mult sequences.
module tb_mult_seq_ctrl;

  localparam int XLEN = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mult_seq_ctrl_if #(.XLEN(XLEN)) bus();

  mult_seq_ctrl #(
    .XLEN  (XLEN),
    .CNT_W (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          early_lat;
  } vec_t;

  vec_t vecs[9];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue at the negedge of cycle T; the k-th following negedge lies in cycle T+k.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input string tag);
    int bad;
    int got;
    @(negedge clk);
    bus.valid_i    = 1'b1;
    bus.alu_ctrl_i = 4'd1;
    bus.op_a_i     = a;
    bus.op_b_i     = b;
    bus.flush_i    = 1'b0;
    #1;
    chk({tag, "_issue_stall"}, 32'(bus.stall_o), 32'd1);
    bad = 0;
    got = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.result_valid_o) begin
        got = k;
        break;
      end
      if (!(bus.stall_o && bus.busy_o)) bad++;
    end
    chk({tag, "_busy_window"}, 32'(bad), 32'd0);
    chk({tag, "_latency"}, 32'(got), 32'(lat));
    chk({tag, "_result"}, bus.result_o, exp);
    chk({tag, "_done_stall"}, 32'(bus.stall_o), 32'd0);
    $display("[TB] mult %h * %h -> %h (expected %h), pulse at T+%0d", a, b, bus.result_o, exp, got);
  endtask

  task automatic idle_window(input logic valid, input logic [3:0] code, input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.valid_i    = valid;
      bus.alu_ctrl_i = code;
      bus.op_a_i     = $urandom;
      bus.op_b_i     = $urandom;
      bus.flush_i    = 1'b0;
      #1;
      if (bus.stall_o || bus.busy_o || bus.result_valid_o) bad++;
    end
    chk({tag, "_no_activity"}, 32'(bad), 32'd0);
    $display("[TB] valid=%0d alu_ctrl=%0d for 10 cycles, %0d active cycles", valid, code, bad);
  endtask

  task automatic no_pulse_window(input int cycles, input string tag);
    int pulses;
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.result_valid_o) pulses++;
    end
    chk({tag, "_no_pulse"}, 32'(pulses), 32'd0);
  endtask

  initial begin
    int lat;

    vecs[0] = '{32'd3,        32'd5,        32'd15,         4};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  33};
    vecs[2] = '{32'h80000000, 32'd2,        32'h00000000,   3};
    vecs[3] = '{32'd7,        32'd2,        32'd14,         3};
    vecs[4] = '{32'd1234,     32'd0,        32'd0,          2};
    vecs[5] = '{32'd2,        32'd4,        32'd8,          4};
    vecs[6] = '{32'h12345678, 32'h10,       32'h23456780,   6};
    vecs[7] = '{32'hDEADBEEF, 32'd1,        32'hDEADBEEF,   2};
    vecs[8] = '{32'h00010001, 32'h00010001, 32'h00020001,  18};

    bus.valid_i    = 1'b0;
    bus.alu_ctrl_i = 4'd0;
    bus.op_a_i     = '0;
    bus.op_b_i     = '0;
    bus.flush_i    = 1'b0;

    // Reset state
    #2;
    chk("reset_stall", 32'(bus.stall_o), 32'd0);
    chk("reset_busy", 32'(bus.busy_o), 32'd0);
    chk("reset_rvalid", 32'(bus.result_valid_o), 32'd0);
    chk("reset_result", bus.result_o, 32'd0);
    $display("[TB] reset state checked");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back mults: each issue lands in the cycle right after DONE
    for (int i = 0; i < 9; i++) begin
`ifdef MULT_EARLY_EXIT_EN
      lat = vecs[i].early_lat;
`else
      lat = XLEN + 1;
`endif
      run_mult(vecs[i].a, vecs[i].b, vecs[i].exp, lat, $sformatf("vec%0d", i));
    end
    @(negedge clk);
    bus.valid_i = 1'b0;
    #1;
    chk("after_done_busy", 32'(bus.busy_o), 32'd0);
    chk("after_done_rvalid", 32'(bus.result_valid_o), 32'd0);
    chk("result_hold", bus.result_o, vecs[8].exp);
    $display("[TB] result held after DONE: %h", bus.result_o);

    // Non-mult codes never stall
    idle_window(1'b1, 4'd2, "add");
    idle_window(1'b1, 4'd6, "sub");
    idle_window(1'b0, 4'd1, "mult_not_valid");

    // Flush in the middle of BUSY
    @(negedge clk);
    bus.valid_i = 1'b1; bus.alu_ctrl_i = 4'd1; bus.op_a_i = 32'd3; bus.op_b_i = 32'd5;
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    #1;
    chk("flush_busy_stall", 32'(bus.stall_o), 32'd0);
    chk("flush_busy_rvalid", 32'(bus.result_valid_o), 32'd0);
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    #1;
    chk("flush_busy_idle", 32'(bus.busy_o), 32'd0);
    no_pulse_window(40, "flush_busy");
    $display("[TB] flush at T+10 checked");

    // Flush in the issue cycle: no stall, no issue
    @(negedge clk);
    bus.valid_i = 1'b1; bus.alu_ctrl_i = 4'd1; bus.flush_i = 1'b1;
    #1;
    chk("flush_issue_stall", 32'(bus.stall_o), 32'd0);
    @(negedge clk);
    bus.valid_i = 1'b0; bus.flush_i = 1'b0;
    #1;
    chk("flush_issue_busy", 32'(bus.busy_o), 32'd0);
    chk("flush_issue_stall2", 32'(bus.stall_o), 32'd0);
    no_pulse_window(40, "flush_issue");
    $display("[TB] flush in issue cycle checked");

    // Reset asserted mid-BUSY
    @(negedge clk);
    bus.valid_i = 1'b1; bus.alu_ctrl_i = 4'd1; bus.op_a_i = 32'd3; bus.op_b_i = 32'd5;
    repeat (5) @(negedge clk);
    chk("pre_reset_busy", 32'(bus.busy_o), 32'd1);
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    #1;
    chk("midreset_stall", 32'(bus.stall_o), 32'd0);
    chk("midreset_busy", 32'(bus.busy_o), 32'd0);
    chk("midreset_rvalid", 32'(bus.result_valid_o), 32'd0);
    chk("midreset_result", bus.result_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    no_pulse_window(40, "midreset");
    chk("midreset_result_after", bus.result_o, 32'd0);
    $display("[TB] reset mid-BUSY checked");

    // A fresh mult still works after the aborted one
`ifdef MULT_EARLY_EXIT_EN
    lat = 3;
`else
    lat = XLEN + 1;
`endif
    run_mult(32'd7, 32'd2, 32'd14, lat, "post_reset");
    @(negedge clk);
    bus.valid_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
